// File: rtl/led_serial_rx_if.sv
// Serial-side bundle for the MiniLED receiver.
// Inputs  : I_dclk, I_sdi, I_le, I_scan[3:0]  (raw panel lines, async to the system clock)
// Outputs : O_valid, O_data, O_word_idx, O_scan, O_frame_done, O_err, O_err_code
// master = the side that drives the serial lines; slave = the receiver.
interface led_serial_rx_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 9
);
  logic              I_dclk;
  logic              I_sdi;
  logic              I_le;
  logic [3:0]        I_scan;
  logic              O_valid;
  logic [DATA_W-1:0] O_data;
  logic [IDX_W-1:0]  O_word_idx;
  logic [1:0]        O_scan;
  logic              O_frame_done;
  logic              O_err;
  logic [1:0]        O_err_code;

  modport master (
    output I_dclk, I_sdi, I_le, I_scan,
    input  O_valid, O_data, O_word_idx, O_scan, O_frame_done, O_err, O_err_code
  );

  modport slave (
    input  I_dclk, I_sdi, I_le, I_scan,
    output O_valid, O_data, O_word_idx, O_scan, O_frame_done, O_err, O_err_code
  );
endinterface

// File: rtl/led_serial_rx.sv
// MiniLED serial receiver: oversamples DCLK/SDI/LE/scan on the system clock,
// rebuilds each latched brightness word and reports it with its frame index
// and the active scan line.
// Ports:
//   I_clk   : system clock (50 MHz)
//   I_rst_n : asynchronous active-low reset, synchronous release
//   bus     : led_serial_rx_if.slave (serial inputs, word/error reporting outputs)
module led_serial_rx #(
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 360,
  parameter int IDX_W   = 9,
  parameter int TIMEOUT = 1024
) (
  input logic            I_clk,
  input logic            I_rst_n,
  led_serial_rx_if.slave bus
);
  localparam int CNT_W  = $clog2(DATA_W + 2);
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam int GAP_W  = $clog2(4 * TIMEOUT);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DATA_W + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(4 * TIMEOUT - 1);

  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Bit layout of the synchronizer pipeline: {scan[3:0], le, sdi, dclk}
  logic [6:0] sync1_q, sync2_q, hist_q;
  logic [1:0] prime_q;
  logic       primed;
  logic       rise_dclk, rise_le, sdi_s;
  logic [3:0] scan_s;

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;

  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_out_q, idx_out_d;
  logic [1:0]        scan_out_q, scan_out_d;
  logic              valid_q, valid_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic [DATA_W-1:0] sh_eff;
  logic [CNT_W-1:0]  cnt_eff;

  function automatic logic [1:0] scan_enc(input logic [3:0] s);
    logic [1:0] r;
    case (s)
      4'b0001: r = 2'd0;
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= {bus.I_scan, bus.I_le, bus.I_sdi, bus.I_dclk};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
  end

  // Edges are masked until the history flop holds a real sample; otherwise a
  // line already high at reset release would look like a rise.
  assign primed    = (prime_q == 2'd3);
  assign rise_dclk = primed & sync2_q[0] & ~hist_q[0];
  assign rise_le   = primed & sync2_q[2] & ~hist_q[2];
  assign sdi_s     = sync2_q[1];
  assign scan_s    = sync2_q[6:3];

  // A DCLK rise in the same cycle as an LE rise shifts first, so the commit
  // sees the post-shift word and count.
  assign sh_eff  = rise_dclk ? {shreg_q[DATA_W-2:0], sdi_s} : shreg_q;
  assign cnt_eff = (rise_dclk && bit_cnt_q != CNT_SAT) ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;

  always_comb begin
    shreg_d    = sh_eff;
    bit_cnt_d  = cnt_eff;
    idle_d     = idle_q;
    gap_d      = gap_q;
    word_idx_d = word_idx_q;
    data_d     = data_q;
    idx_out_d  = idx_out_q;
    scan_out_d = scan_out_q;
    valid_d    = 1'b0;
    fd_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;

    // Long silence on both DCLK and LE marks a frame boundary.
    if (rise_dclk || rise_le) begin
      gap_d = '0;
    end else if (gap_q != GAP_LAST) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      word_idx_d = '0;
    end

    if (rise_le) begin
      bit_cnt_d = '0;
      idle_d    = '0;
      if (cnt_eff == CNT_FULL) begin
        data_d     = sh_eff;
        idx_out_d  = word_idx_q;
        scan_out_d = scan_enc(scan_s);
        valid_d    = 1'b1;
        fd_d       = (word_idx_q == IDX_LAST);
        word_idx_d = (word_idx_q == IDX_LAST) ? '0 : word_idx_q + IDX_W'(1);
      end else begin
        err_d  = 1'b1;
        code_d = (cnt_eff < CNT_FULL) ? ERR_SHORT : ERR_OVERRUN;
      end
    end else if (rise_dclk) begin
      idle_d = '0;
    end else if (bit_cnt_q != '0) begin
      if (idle_q == IDLE_LAST) begin
        bit_cnt_d = '0;
        idle_d    = '0;
        err_d     = 1'b1;
        code_d    = ERR_TIMEOUT;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      idle_q     <= '0;
      gap_q      <= '0;
      word_idx_q <= '0;
      data_q     <= '0;
      idx_out_q  <= '0;
      scan_out_q <= '0;
      valid_q    <= 1'b0;
      fd_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_q     <= idle_d;
      gap_q      <= gap_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
      idx_out_q  <= idx_out_d;
      scan_out_q <= scan_out_d;
      valid_q    <= valid_d;
      fd_q       <= fd_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign bus.O_valid      = valid_q;
  assign bus.O_data       = data_q;
  assign bus.O_word_idx   = idx_out_q;
  assign bus.O_scan       = scan_out_q;
  assign bus.O_frame_done = fd_q;
  assign bus.O_err        = err_q;
  assign bus.O_err_code   = code_q;
endmodule

// File: tb/tb_led_serial_rx.sv
module tb_led_serial_rx;
  localparam int DATA_W  = 16;
  localparam int N_WORDS = 360;
  localparam int IDX_W   = 9;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  led_serial_rx_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  led_serial_rx #(.DATA_W(DATA_W), .N_WORDS(N_WORDS), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    logic [8:0]  idx;
    logic [1:0]  scan;
    logic        fd;
    logic [1:0]  code;
  } ev_t;

  ev_t  evq[$];
  bit   bitq[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   exp_idx = 0;
  logic [15:0] last_data = '0;
  logic [3:0]  cur_scan = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference scan decode: position of the single set bit, else 0.
  function automatic logic [1:0] ref_scan(input logic [3:0] s);
    if ($countones(s) != 1) return 2'd0;
    for (int i = 0; i < 4; i++) if (s[i]) return 2'(i);
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (bus.O_valid || bus.O_err || bus.O_frame_done)) begin
      ev_t e;
      if (bus.O_frame_done) chk("frame_done_needs_valid", 32'(bus.O_valid), 32'd1);
      if (bus.O_valid)      chk("valid_err_exclusive", 32'(bus.O_err), 32'd0);
      e.is_err = bus.O_err;
      e.data   = bus.O_data;
      e.idx    = bus.O_word_idx;
      e.scan   = bus.O_scan;
      e.fd     = bus.O_frame_done;
      e.code   = bus.O_err_code;
      evq.push_back(e);
    end
  end

  task automatic drive_bit(input bit b, input bit with_le);
    bus.I_sdi  = b;
    bus.I_dclk = 1'b0;
    step(2);
    bus.I_dclk = 1'b1;
    if (with_le) bus.I_le = 1'b1;
    step(2);
    bitq.push_back(b);
  endtask

  task automatic send_bits(input int n, input logic [31:0] val, input bit sim_le);
    for (int i = n - 1; i >= 0; i--) drive_bit(val[i], sim_le && (i == 0));
  endtask

  task automatic finish_word(input string tag, input bit le_done);
    ev_t e;
    int n;
    logic [15:0] w;
    if (!le_done) begin
      bus.I_dclk = 1'b0;
      bus.I_le   = 1'b1;
      step(3);
    end else begin
      step(1);
    end
    bus.I_le   = 1'b0;
    bus.I_dclk = 1'b0;
    for (int i = 0; i < 16 && evq.size() == 0; i++) step(1);
    chk({tag, "_event_seen"}, 32'(evq.size() != 0), 32'd1);
    n = bitq.size();
    w = '0;
    for (int i = (n > 16) ? n - 16 : 0; i < n; i++) w = {w[14:0], bitq[i]};
    if (evq.size() != 0) begin
      e = evq.pop_front();
      if (n == 16) begin
        chk({tag, "_is_valid"}, 32'(e.is_err), 32'd0);
        chk({tag, "_data"}, 32'(e.data), 32'(w));
        chk({tag, "_idx"}, 32'(e.idx), 32'(exp_idx));
        chk({tag, "_scan"}, 32'(e.scan), 32'(ref_scan(cur_scan)));
        chk({tag, "_frame_done"}, 32'(e.fd), 32'(exp_idx == N_WORDS - 1));
        last_data = w;
        exp_idx = (exp_idx + 1) % N_WORDS;
      end else begin
        chk({tag, "_is_err"}, 32'(e.is_err), 32'd1);
        chk({tag, "_err_code"}, 32'(e.code), (n < 16) ? 32'd1 : 32'd2);
        chk({tag, "_data_held"}, 32'(bus.O_data), 32'(last_data));
      end
    end
    bitq.delete();
    step(4);
    chk({tag, "_no_extra_event"}, 32'(evq.size()), 32'd0);
    evq.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.O_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.O_data), 32'd0);
    chk({tag, "_idx"}, 32'(bus.O_word_idx), 32'd0);
    chk({tag, "_scan"}, 32'(bus.O_scan), 32'd0);
    chk({tag, "_fd"}, 32'(bus.O_frame_done), 32'd0);
    chk({tag, "_err"}, 32'(bus.O_err), 32'd0);
    chk({tag, "_code"}, 32'(bus.O_err_code), 32'd0);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int first_err;
    bit sim;
    logic [31:0] val;

    bus.I_dclk = 1'b0;
    bus.I_sdi  = 1'b0;
    bus.I_le   = 1'b0;
    bus.I_scan = 4'b0000;
    step(4);
    check_outputs_zero("in_reset");
    rst_n = 1'b1;
    step(6);
    check_outputs_zero("after_reset");

    // First word after reset
    cur_scan = 4'b0100;
    bus.I_scan = cur_scan;
    send_bits(16, 32'hA5C3, 1'b0);
    finish_word("first_word", 1'b0);
    chk("first_word_o_data", 32'(bus.O_data), 32'hA5C3);

    // Long silence resets the frame position
    step(4 * TIMEOUT + 100);
    exp_idx = 0;

    // One full frame, data = index, random scan pattern
    for (int i = 0; i < N_WORDS; i++) begin
      cur_scan = 4'($urandom_range(0, 15));
      bus.I_scan = cur_scan;
      send_bits(16, 32'(i), 1'b0);
      finish_word("frame_word", 1'b0);
    end
    cur_scan = 4'b0001;
    bus.I_scan = cur_scan;
    send_bits(16, 32'h1234, 1'b0);
    finish_word("wrap_word", 1'b0);

    // Short and overrun words
    send_bits(15, $urandom, 1'b0);
    finish_word("short_word", 1'b0);
    send_bits(16, $urandom, 1'b0);
    finish_word("after_short", 1'b0);
    send_bits(17, $urandom, 1'b0);
    finish_word("overrun_word", 1'b0);

    // Partial word then silence
    send_bits(8, $urandom, 1'b0);
    bus.I_dclk = 1'b0;
    first_err = -1;
    for (k = 1; k <= TIMEOUT + 40 && first_err < 0; k++) begin
      step(1);
      if (evq.size() != 0) first_err = k;
    end
    chk("timeout_seen", 32'(first_err >= 0), 32'd1);
    chk("timeout_not_early", 32'(first_err >= TIMEOUT + 1), 32'd1);
    chk("timeout_not_late", 32'(first_err <= TIMEOUT + 5), 32'd1);
    if (evq.size() != 0) begin
      ev_t e;
      e = evq.pop_front();
      chk("timeout_is_err", 32'(e.is_err), 32'd1);
      chk("timeout_code", 32'(e.code), 32'd3);
    end
    bitq.delete();
    step(4);
    chk("timeout_no_extra", 32'(evq.size()), 32'd0);
    evq.delete();
    send_bits(16, $urandom, 1'b0);
    finish_word("after_timeout", 1'b0);

    // Last DCLK rise and LE rise in the same cycle
    cur_scan = 4'b1000;
    bus.I_scan = cur_scan;
    send_bits(16, $urandom, 1'b1);
    finish_word("simultaneous", 1'b1);

    // Random mix
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 4);
      n = (k == 0) ? 15 : (k == 4) ? 17 : 16;
      sim = (n == 16) && ($urandom_range(0, 3) == 0);
      cur_scan = 4'($urandom_range(0, 15));
      bus.I_scan = cur_scan;
      val = $urandom;
      send_bits(n, val, sim);
      finish_word("random_word", sim);
      step($urandom_range(0, 10));
    end

    // Reset mid-word with LE held high across release
    send_bits(7, $urandom, 1'b0);
    bus.I_dclk = 1'b0;
    bus.I_le = 1'b1;
    step(2);
    rst_n = 1'b0;
    step(3);
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("release_no_valid", 32'(bus.O_valid), 32'd0);
      chk("release_no_err", 32'(bus.O_err), 32'd0);
    end
    check_outputs_zero("post_release");
    bus.I_le = 1'b0;
    step(4);
    evq.delete();
    bitq.delete();
    exp_idx = 0;
    cur_scan = 4'b0010;
    bus.I_scan = cur_scan;
    send_bits(16, $urandom, 1'b0);
    finish_word("post_reset_word", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
